// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: serialises framer output onto the UART TX pin, LSB (start bit) first.
// Each bit is held for CLKS_PER_BIT clocks; the idle line is high.
// Optional feature: define UART_TX_HOLD_BUF_EN to add a one-entry holding register so
// that a queued frame follows the previous stop bit with no idle gap.
module uart_tx_shifter #(
    parameter int FRAME_W      = 11,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic [3:0]         frame_len,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CLK_TERM = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      FULL_LEN = 4'(FRAME_W);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [3:0]         len_q, len_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic               bit_end;
    logic               frame_end;
    logic [3:0]         in_len;

`ifdef UART_TX_HOLD_BUF_EN
    logic [FRAME_W-1:0] hold_frame_q, hold_frame_d;
    logic [3:0]         hold_len_q, hold_len_d;
    logic               hold_full_q, hold_full_d;
`endif

    // Out-of-range lengths (too short to carry a start bit plus data, or wider
    // than the frame) fall back to the full frame width.
    function automatic logic [3:0] eff_len(input logic [3:0] l);
        if (l < 4'd2 || int'(l) > FRAME_W) begin
            return FULL_LEN;
        end
        return l;
    endfunction

    // Handshake qualification and end-of-bit / end-of-frame detection.
    always_comb begin
        bit_end   = (state_q == S_SHIFT) && (clk_cnt_q == CLK_TERM);
        frame_end = bit_end && (bit_cnt_q == (len_q - 4'd1));
        in_len    = eff_len(frame_len);
`ifdef UART_TX_HOLD_BUF_EN
        // The hold slot also frees up in the cycle it drains into the shifter.
        frame_ready = ~hold_full_q | frame_end;
`else
        frame_ready = ~busy_q & ~rst;
`endif
        accept = frame_valid & frame_ready;
    end

    // Next-state logic for the shifter, counters and the registered outputs.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = clk_cnt_q;
`ifdef UART_TX_HOLD_BUF_EN
        hold_frame_d = hold_frame_q;
        hold_len_d   = hold_len_q;
        hold_full_d  = hold_full_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SHIFT;
                    shift_d   = frame_in;
                    len_d     = in_len;
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
                if (frame_end) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
`ifdef UART_TX_HOLD_BUF_EN
                    if (hold_full_q) begin
                        state_d     = S_SHIFT;
                        shift_d     = hold_frame_q;
                        len_d       = hold_len_q;
                        hold_full_d = accept;
                        if (accept) begin
                            hold_frame_d = frame_in;
                            hold_len_d   = in_len;
                        end
                    end else if (accept) begin
                        state_d = S_SHIFT;
                        shift_d = frame_in;
                        len_d   = in_len;
                    end
`endif
                end else begin
                    if (bit_end) begin
                        shift_d   = {1'b1, shift_q[FRAME_W-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
`ifdef UART_TX_HOLD_BUF_EN
                    if (accept) begin
                        hold_frame_d = frame_in;
                        hold_len_d   = in_len;
                        hold_full_d  = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state:
        // done is high during the final clock of the final bit period.
        tx_d   = (state_d == S_SHIFT) ? shift_d[0] : 1'b1;
        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_SHIFT) && (clk_cnt_d == CLK_TERM) &&
                 (bit_cnt_d == (len_d - 4'd1));
    end

    // State register with synchronous reset; a reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            len_q     <= FULL_LEN;
            bit_cnt_q <= '0;
            clk_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
            hold_frame_q <= '0;
            hold_len_q   <= FULL_LEN;
            hold_full_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_HOLD_BUF_EN
            hold_frame_q <= hold_frame_d;
            hold_len_q   <= hold_len_d;
            hold_full_q  <= hold_full_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_shifter.sv
// tb_uart_tx_shifter: directed frames with a scoreboard queue of expected frames;
// a monitor reassembles each serial frame from tx and checks it on every done pulse.
module tb_uart_tx_shifter;

    localparam int FRAME_W = 11;
    localparam int CPB     = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [FRAME_W-1:0] frame_in = '1;
    logic [3:0]         frame_len = 4'd11;
    logic               frame_valid = 1'b0;
    logic               frame_ready;
    logic               tx;
    logic               busy;
    logic               done;

    typedef struct {
        logic [10:0] bits;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    int nCompared   = 0;
    int nMismatched = 0;
    int nDone       = 0;

    int          fcyc   = 0;
    logic [15:0] rxBits = '1;
    logic        glitch = 1'b0;

    uart_tx_shifter #(
        .FRAME_W     (FRAME_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_in   (frame_in),
        .frame_len  (frame_len),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame and waits (bounded) for it to be accepted; the expected
    // serial image is queued only for frames that should complete.
    task automatic applyStimulus(input logic [10:0] f, input logic [3:0] l,
                                 input logic [10:0] expBits, input int expCycles,
                                 input bit keepValid, input bit expectDone);
        int waitCyc = 0;
        frame_in    = f;
        frame_len   = l;
        frame_valid = 1'b1;
        while (!frame_ready && waitCyc < 200) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        if (!frame_ready) begin
            checkOutput("accept_timeout", 32'(frame_ready), 32'd1);
            frame_valid = 1'b0;
            return;
        end
        if (expectDone) sb.push_back('{expBits, expCycles});
        @(posedge clk); #1;
        if (!keepValid) begin
            frame_valid = 1'b0;
            frame_in    = 11'h3C5;
            frame_len   = 4'd3;
        end
    endtask

    // Bounded wait until the shifter is idle.
    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    // Monitor: rebuilds the frame from tx, checks bit stability and frame length.
    always @(negedge clk) begin
        if (rst) begin
            fcyc   = 0;
            rxBits = '1;
            glitch = 1'b0;
        end else if (busy) begin
            if (fcyc < 64) begin
                if ((fcyc % CPB) == 0) rxBits[fcyc / CPB] = tx;
                else if (tx !== rxBits[fcyc / CPB]) glitch = 1'b1;
            end
            fcyc++;
            if (done) begin
                nDone++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t        e;
                    logic [15:0] mask;
                    e    = sb.pop_front();
                    mask = (16'h1 << (e.cycles / CPB)) - 16'h1;
                    checkOutput("frame_bits", 32'(rxBits & mask), 32'({5'b0, e.bits} & mask));
                    checkOutput("frame_cycles", 32'(fcyc), 32'(e.cycles));
                    checkOutput("bit_stable", 32'(glitch), 32'd0);
                end
                fcyc   = 0;
                rxBits = '1;
                glitch = 1'b0;
            end
        end else if (done) begin
            checkOutput("done_while_idle", 32'd1, 32'd0);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        // Reset for three cycles, then check idle state.
        repeat (3) @(posedge clk);
        #1;
`ifndef UART_TX_HOLD_BUF_EN
        checkOutput("ready_in_reset", 32'(frame_ready), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_ready", 32'(frame_ready), 32'd1);

        // Full 11-bit frame: 0,1,0,1,0,1,0,1,1,1,1; start bit the cycle after accept.
        applyStimulus(11'h7AA, 4'd11, 11'h7AA, 44, 1'b0, 1'b1);
        checkOutput("start_bit", 32'(tx), 32'd0);
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("done_edge", 32'(n), 32'd43);
            @(posedge clk); #1;
            checkOutput("busy_falls_after_done", 32'(busy), 32'd0);
            checkOutput("done_one_cycle", 32'(done), 32'd0);
            checkOutput("idle_tx", 32'(tx), 32'd1);
        end

        // Shorter and out-of-range lengths.
        applyStimulus(11'h2AA, 4'd10, 11'h2AA, 40, 1'b0, 1'b1);
        waitIdle("idle_len10");
        applyStimulus(11'h5A4, 4'd0, 11'h5A4, 44, 1'b0, 1'b1);
        waitIdle("idle_len0");
        applyStimulus(11'h3B6, 4'd1, 11'h3B6, 44, 1'b0, 1'b1);
        waitIdle("idle_len1");
        applyStimulus(11'h1D2, 4'd15, 11'h1D2, 44, 1'b0, 1'b1);
        waitIdle("idle_len15");
        applyStimulus(11'h7FE, 4'd2, 11'h002, 8, 1'b0, 1'b1);
        waitIdle("idle_len2");

`ifndef UART_TX_HOLD_BUF_EN
        // Valid held through a frame while frame_in changes: only one frame,
        // the next is taken once busy has dropped.
        applyStimulus(11'h7AA, 4'd11, 11'h7AA, 44, 1'b1, 1'b1);
        frame_in  = 11'h6B2;
        frame_len = 4'd11;
        sb.push_back('{11'h6B2, 44});
        repeat (10) @(posedge clk);
        #1;
        checkOutput("ready_low_while_busy", 32'(frame_ready), 32'd0);
        checkOutput("busy_mid_frame", 32'(busy), 32'd1);
        begin
            int n = 0;
            while (busy && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("ready_after_busy", 32'(frame_ready), 32'd1);
            @(posedge clk); #1;
            frame_valid = 1'b0;
            checkOutput("second_accept", 32'(busy), 32'd1);
        end
        waitIdle("idle_held_valid");
`else
        // Back-to-back frames through the holding register; third stalls.
        applyStimulus(11'h7AA, 4'd11, 11'h7AA, 44, 1'b0, 1'b1);
        applyStimulus(11'h6B2, 4'd11, 11'h6B2, 44, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ready_low_hold_full", 32'(frame_ready), 32'd0);
        applyStimulus(11'h2AA, 4'd10, 11'h2AA, 40, 1'b0, 1'b1);
        checkOutput("busy_back_to_back", 32'(busy), 32'd1);
        waitIdle("idle_hold");
`endif

        // Reset during bit 5 of a frame: line returns to idle, no done.
        applyStimulus(11'h555, 4'd11, 11'h555, 44, 1'b0, 1'b0);
        repeat (21) @(posedge clk);
        #1;
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_tx", 32'(tx), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(11'h7AA, 4'd11, 11'h7AA, 44, 1'b0, 1'b1);
        waitIdle("idle_after_abort");

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifndef UART_TX_HOLD_BUF_EN
        checkOutput("done_count", 32'(nDone), 32'd9);
`else
        checkOutput("done_count", 32'(nDone), 32'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
